// File: rtl/can_defines_pkg.sv
// Shared widths and FSM encoding for the CAN ID-hopping table controller.
package can_defines;

  localparam int unsigned ID_W   = 11;
  localparam int unsigned PRIO_W = 4;
  localparam int unsigned PAGE_W = 4;
  localparam int unsigned ADDR_W = PAGE_W + PRIO_W;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StTxRd,
    StTxRsp,
    StRxScan,
    StRxRsp
  } state_e;

endpackage

// File: rtl/can_id_hop_ctrl_if.sv
// Requester-side bundle: cfg/tx/rx handshakes, hopping key/frame events, page and busy status.
interface can_id_hop_ctrl_if;
  import can_defines::*;

  logic              cfg_req;
  logic [PAGE_W-1:0] cfg_page;
  logic [PRIO_W-1:0] cfg_prio;
  logic [ID_W-1:0]   cfg_id;
  logic              cfg_ack;

  logic              key_we;
  logic [PAGE_W-1:0] key;
  logic              frame_done;

  logic              tx_req;
  logic [PRIO_W-1:0] tx_prio;
  logic              tx_ack;
  logic [ID_W-1:0]   tx_id;

  logic              rx_req;
  logic [ID_W-1:0]   rx_id;
  logic              rx_ack;
  logic              rx_hit;
  logic [PRIO_W-1:0] rx_prio;

  logic [PAGE_W-1:0] page;
  logic              busy;

  modport master (
    output cfg_req, cfg_page, cfg_prio, cfg_id, key_we, key, frame_done,
           tx_req, tx_prio, rx_req, rx_id,
    input  cfg_ack, tx_ack, tx_id, rx_ack, rx_hit, rx_prio, page, busy
  );

  modport slave (
    input  cfg_req, cfg_page, cfg_prio, cfg_id, key_we, key, frame_done,
           tx_req, tx_prio, rx_req, rx_id,
    output cfg_ack, tx_ack, tx_id, rx_ack, rx_hit, rx_prio, page, busy
  );

endinterface

// File: rtl/can_id_hop_mem.sv
// 256 x 11 single-port RAM, registered read data, write-first. Contents are not reset.
module can_id_hop_mem
  import can_defines::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ID_W-1:0]   wdata,
  output logic [ID_W-1:0]   rdata
);

  logic [ID_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/can_id_hop_ctrl.sv
// Arbitrates cfg writes, tx lookups and rx reverse scans over the shared ID table and
// maintains the hopping page (hop counter XOR key).
module can_id_hop_ctrl
  import can_defines::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  can_id_hop_ctrl_if.slave       bus
);

  state_e            state_q, state_d;
  logic [PAGE_W-1:0] page_l_q, page_l_d;
  logic [PRIO_W-1:0] prio_l_q, prio_l_d;
  logic [ID_W-1:0]   id_l_q, id_l_d;
  logic [PRIO_W-1:0] scan_q, scan_d, scan_nxt;
  logic [PAGE_W-1:0] hop_q, hop_d, key_q, key_d;
  logic [ID_W-1:0]   tx_id_q, tx_id_d;
  logic              rx_hit_q, rx_hit_d;
  logic [PRIO_W-1:0] rx_prio_q, rx_prio_d;
  logic              cfg_ack_q, cfg_ack_d, tx_ack_q, tx_ack_d, rx_ack_q, rx_ack_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ID_W-1:0]   mem_rdata;
  logic [PAGE_W-1:0] page;

  assign page     = hop_q ^ key_q;
  assign scan_nxt = scan_q + PRIO_W'(1);

  can_id_hop_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (id_l_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    page_l_d  = page_l_q;
    prio_l_d  = prio_l_q;
    id_l_d    = id_l_q;
    scan_d    = scan_q;
    tx_id_d   = tx_id_q;
    rx_hit_d  = rx_hit_q;
    rx_prio_d = rx_prio_q;
    cfg_ack_d = 1'b0;
    tx_ack_d  = 1'b0;
    rx_ack_d  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {page_l_q, prio_l_q};

    // A requester still showing its ack is masked so a held request is not served twice.
    unique case (state_q)
      StIdle: begin
        mem_addr = {page, {PRIO_W{1'b0}}};  // pre-issue index 0 in case a scan starts now
        if (bus.rx_req && !rx_ack_q) begin
          state_d  = StRxScan;
          page_l_d = page;
          id_l_d   = bus.rx_id;
          scan_d   = '0;
        end else if (bus.tx_req && !tx_ack_q) begin
          state_d  = StTxRd;
          page_l_d = page;
          prio_l_d = bus.tx_prio;
        end else if (bus.cfg_req && !cfg_ack_q) begin
          state_d  = StWr;
          page_l_d = bus.cfg_page;
          prio_l_d = bus.cfg_prio;
          id_l_d   = bus.cfg_id;
        end
      end
      StWr: begin
        mem_we    = 1'b1;
        cfg_ack_d = 1'b1;
        state_d   = StIdle;
      end
      StTxRd: state_d = StTxRsp;
      StTxRsp: begin
        tx_id_d  = mem_rdata;
        tx_ack_d = 1'b1;
        state_d  = StIdle;
      end
      StRxScan: begin
        // mem_rdata holds entry scan_q; fetch the next one in parallel.
        mem_addr = {page_l_q, scan_nxt};
        if (mem_rdata == id_l_q) begin
          rx_hit_d  = 1'b1;
          rx_prio_d = scan_q;
          state_d   = StRxRsp;
        end else if (&scan_q) begin
          rx_hit_d  = 1'b0;
          rx_prio_d = '0;
          state_d   = StRxRsp;
        end else begin
          scan_d = scan_nxt;
        end
      end
      StRxRsp: begin
        rx_ack_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hop_d = hop_q;
    key_d = key_q;
    if (bus.key_we) begin
      key_d = bus.key;
      hop_d = '0;
    end else if (bus.frame_done) begin
      hop_d = hop_q + PAGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      page_l_q  <= '0;
      prio_l_q  <= '0;
      id_l_q    <= '0;
      scan_q    <= '0;
      hop_q     <= '0;
      key_q     <= '0;
      tx_id_q   <= '0;
      rx_hit_q  <= 1'b0;
      rx_prio_q <= '0;
      cfg_ack_q <= 1'b0;
      tx_ack_q  <= 1'b0;
      rx_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_l_q  <= page_l_d;
      prio_l_q  <= prio_l_d;
      id_l_q    <= id_l_d;
      scan_q    <= scan_d;
      hop_q     <= hop_d;
      key_q     <= key_d;
      tx_id_q   <= tx_id_d;
      rx_hit_q  <= rx_hit_d;
      rx_prio_q <= rx_prio_d;
      cfg_ack_q <= cfg_ack_d;
      tx_ack_q  <= tx_ack_d;
      rx_ack_q  <= rx_ack_d;
    end
  end

  assign bus.cfg_ack = cfg_ack_q;
  assign bus.tx_ack  = tx_ack_q;
  assign bus.tx_id   = tx_id_q;
  assign bus.rx_ack  = rx_ack_q;
  assign bus.rx_hit  = rx_hit_q;
  assign bus.rx_prio = rx_prio_q;
  assign bus.page    = page;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_can_id_hop_ctrl.sv
// Directed, table-driven bench for can_id_hop_ctrl with hand sequences for arbitration,
// hop/key races and reset during a scan.
module tb_can_id_hop_ctrl;
  import can_defines::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  can_id_hop_ctrl_if bus ();

  can_id_hop_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_rx;
    logic [3:0]  key;
    logic [3:0]  prio;
    logic [10:0] id;
    logic        exp_hit;
    logic [3:0]  exp_prio;
    logic [10:0] exp_id;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lat = index of the edge after which ack is seen, counting the sampling edge as 0
  task automatic cfg_write(input logic [3:0] pg, input logic [3:0] pr, input logic [10:0] id,
                           output int lat);
    bus.cfg_page = pg; bus.cfg_prio = pr; bus.cfg_id = id; bus.cfg_req = 1'b1;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.cfg_ack) begin lat = c; break; end
    end
    bus.cfg_req = 1'b0;
    step();
  endtask

  task automatic tx_lookup(input logic [3:0] pr, output logic [10:0] id, output int lat);
    bus.tx_prio = pr; bus.tx_req = 1'b1;
    lat = -1; id = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.tx_ack) begin lat = c; id = bus.tx_id; break; end
    end
    bus.tx_req = 1'b0;
    step();
  endtask

  task automatic rx_lookup(input logic [10:0] id, output logic hit, output logic [3:0] pr,
                           output int lat);
    bus.rx_id = id; bus.rx_req = 1'b1;
    lat = -1; hit = 1'b0; pr = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.rx_ack) begin lat = c; hit = bus.rx_hit; pr = bus.rx_prio; break; end
    end
    bus.rx_req = 1'b0;
    step();
  endtask

  task automatic key_load(input logic [3:0] k);
    bus.key = k; bus.key_we = 1'b1;
    step();
    bus.key_we = 1'b0;
  endtask

  task automatic frame_pulse();
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cfg_ack"}, 32'(bus.cfg_ack), 0);
    check({tag, "_tx_ack"},  32'(bus.tx_ack),  0);
    check({tag, "_rx_ack"},  32'(bus.rx_ack),  0);
    check({tag, "_tx_id"},   32'(bus.tx_id),   0);
    check({tag, "_rx_hit"},  32'(bus.rx_hit),  0);
    check({tag, "_rx_prio"}, 32'(bus.rx_prio), 0);
    check({tag, "_page"},    32'(bus.page),    0);
    check({tag, "_busy"},    32'(bus.busy),    0);
  endtask

  initial begin
    int          lat, bad, n_ack;
    logic [10:0] id;
    logic        hit;
    logic [3:0]  pr;

    vecs[0] = '{1'b0, 4'd0,  4'd2,  11'h000, 1'b0, 4'd0,  11'h003, 2};
    vecs[1] = '{1'b0, 4'd7,  4'd15, 11'h000, 1'b0, 4'd0,  11'h080, 2};
    vecs[2] = '{1'b0, 4'd15, 4'd0,  11'h000, 1'b0, 4'd0,  11'h0F1, 2};
    vecs[3] = '{1'b1, 4'd0,  4'd0,  11'h00A, 1'b1, 4'd9,  11'h000, 11};
    vecs[4] = '{1'b1, 4'd0,  4'd0,  11'h7FF, 1'b0, 4'd0,  11'h000, 17};
    vecs[5] = '{1'b1, 4'd5,  4'd0,  11'h051, 1'b1, 4'd0,  11'h000, 2};
    vecs[6] = '{1'b1, 4'd5,  4'd0,  11'h060, 1'b1, 4'd15, 11'h000, 17};
    vecs[7] = '{1'b1, 4'd5,  4'd0,  11'h00A, 1'b0, 4'd0,  11'h000, 17};
    vecs[8] = '{1'b1, 4'd9,  4'd0,  11'h09A, 1'b1, 4'd9,  11'h000, 11};

    bus.cfg_req = 0; bus.cfg_page = 0; bus.cfg_prio = 0; bus.cfg_id = 0;
    bus.key_we = 0; bus.key = 0; bus.frame_done = 0;
    bus.tx_req = 0; bus.tx_prio = 0; bus.rx_req = 0; bus.rx_id = 0;

    repeat (3) step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // Configuration then translated lookup through the keyed page
    cfg_write(4'd3, 4'd5, 11'h1A5, lat);
    check("cfg_lat", 32'(lat), 1);
    key_load(4'd3);
    check("cfg_page3", 32'(bus.page), 3);
    tx_lookup(4'd5, id, lat);
    check("cfg_tx_lat", 32'(lat), 2);
    check("cfg_tx_id", 32'(id), 32'h1A5);

    // Fill every page with page*16 + prio + 1
    bad = 0;
    for (int p = 0; p < 16; p++) begin
      for (int q = 0; q < 16; q++) begin
        cfg_write(4'(p), 4'(q), 11'(p * 16 + q + 1), lat);
        if (lat != 1) bad++;
      end
    end
    check("fill_acks", 32'(bad), 0);

    // Hopping: 17 frames walk 1..15, 0, 1
    key_load(4'd0);
    check("hop_start", 32'(bus.page), 0);
    for (int i = 1; i <= 17; i++) begin
      frame_pulse();
      check($sformatf("hop_page_%0d", i), 32'(bus.page), 32'(i % 16));
    end
    tx_lookup(4'd2, id, lat);
    check("hop_tx_id", 32'(id), 32'h013);

    // Table-driven lookups
    foreach (vecs[i]) begin
      key_load(vecs[i].key);
      if (vecs[i].is_rx) begin
        rx_lookup(vecs[i].id, hit, pr, lat);
        check($sformatf("vec%0d_hit", i),  32'(hit), 32'(vecs[i].exp_hit));
        check($sformatf("vec%0d_prio", i), 32'(pr),  32'(vecs[i].exp_prio));
      end else begin
        tx_lookup(vecs[i].prio, id, lat);
        check($sformatf("vec%0d_id", i), 32'(id), 32'(vecs[i].exp_id));
      end
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Duplicate IDs resolve to the lowest index
    cfg_write(4'd0, 4'd12, 11'h055, lat);
    cfg_write(4'd0, 4'd4, 11'h055, lat);
    key_load(4'd0);
    rx_lookup(11'h055, hit, pr, lat);
    check("dup_hit", 32'(hit), 1);
    check("dup_prio", 32'(pr), 4);
    check("dup_lat", 32'(lat), 6);

    // Arbitration: all three together, each requester drops req the cycle after its ack
    begin
      int rx_at = -1, tx_at = -1, cfg_at = -1, rx_n = 0, tx_n = 0, cfg_n = 0;
      logic [10:0] tx_got = '0;
      logic [3:0]  rx_got = '0;
      bus.rx_id = 11'h003; bus.tx_prio = 4'd1;
      bus.cfg_page = 4'd2; bus.cfg_prio = 4'd0; bus.cfg_id = 11'h123;
      bus.rx_req = 1; bus.tx_req = 1; bus.cfg_req = 1;
      for (int c = 0; c < 30; c++) begin
        step();
        if (rx_at >= 0)  bus.rx_req  = 0;
        if (tx_at >= 0)  bus.tx_req  = 0;
        if (cfg_at >= 0) bus.cfg_req = 0;
        if (bus.rx_ack) begin rx_n++; if (rx_at < 0) begin rx_at = c; rx_got = bus.rx_prio; end end
        if (bus.tx_ack) begin tx_n++; if (tx_at < 0) begin tx_at = c; tx_got = bus.tx_id; end end
        if (bus.cfg_ack) begin cfg_n++; if (cfg_at < 0) cfg_at = c; end
      end
      bus.rx_req = 0; bus.tx_req = 0; bus.cfg_req = 0;
      check("arb_rx_at", 32'(rx_at), 4);
      check("arb_tx_at", 32'(tx_at), 7);
      check("arb_cfg_at", 32'(cfg_at), 9);
      check("arb_rx_pulses", 32'(rx_n), 1);
      check("arb_tx_pulses", 32'(tx_n), 1);
      check("arb_cfg_pulses", 32'(cfg_n), 1);
      check("arb_rx_prio", 32'(rx_got), 2);
      check("arb_tx_id", 32'(tx_got), 32'h002);
    end
    key_load(4'd2);
    tx_lookup(4'd0, id, lat);
    check("arb_cfg_written", 32'(id), 32'h123);

    // key_we wins over a simultaneous frame_done
    key_load(4'd0);
    repeat (3) frame_pulse();
    check("race_pre", 32'(bus.page), 3);
    bus.key = 4'd6; bus.key_we = 1; bus.frame_done = 1;
    step();
    bus.key_we = 0; bus.frame_done = 0;
    check("race_key_wins", 32'(bus.page), 6);
    frame_pulse();
    check("race_after", 32'(bus.page), 7);

    // frame_done during a scan: result stays on the page latched at acceptance
    key_load(4'd0);
    bus.rx_id = 11'h00A; bus.rx_req = 1;
    lat = -1; hit = 0; pr = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      bus.frame_done = (c == 2);
      if (bus.rx_ack) begin lat = c; hit = bus.rx_hit; pr = bus.rx_prio; break; end
    end
    bus.rx_req = 0; bus.frame_done = 0;
    step();
    check("scan_hop_lat", 32'(lat), 11);
    check("scan_hop_hit", 32'(hit), 1);
    check("scan_hop_prio", 32'(pr), 9);
    check("scan_hop_page", 32'(bus.page), 1);

    // Reset while the scan sits at index 6
    key_load(4'd5);
    bus.rx_id = 11'h7FF; bus.rx_req = 1;
    n_ack = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      if (bus.rx_ack) n_ack++;
    end
    check("rst_busy_before", 32'(bus.busy), 1);
    rst_n = 0; bus.rx_req = 0;
    step();
    rst_n = 1;
    check_idle_outputs("rst_mid");
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.rx_ack) n_ack++;
    end
    check("rst_no_rx_ack", 32'(n_ack), 0);
    tx_lookup(4'd2, id, lat);
    check("rst_tx_lat", 32'(lat), 2);
    check("rst_tx_id", 32'(id), 32'h003);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
